// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bus: redirect/stall inputs, instruction-memory handshake and fetch outputs.
// Optional macro PC_REDIRECT_COUNT_EN adds the redirect_cnt signal.
interface pc_fetch_unit_if;
   logic [31:0] target;
   logic        taken;
   logic        dbusywait;
   logic        ibusywait;
   logic [31:0] ireaddata;
   logic [31:0] pc;
   logic        iread;
   logic [31:0] instruction;
   logic        instr_valid;
`ifdef PC_REDIRECT_COUNT_EN
   logic [15:0] redirect_cnt;
`endif

   modport master (
      input  target, taken, dbusywait, ibusywait, ireaddata,
`ifdef PC_REDIRECT_COUNT_EN
      output redirect_cnt,
`endif
      output pc, iread, instruction, instr_valid
   );

   modport slave (
      output target, taken, dbusywait, ibusywait, ireaddata,
`ifdef PC_REDIRECT_COUNT_EN
      input  redirect_cnt,
`endif
      input  pc, iread, instruction, instr_valid
   );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch sequencer (IDLE -> FETCH -> EXEC loop).
// Optional macro PC_REDIRECT_COUNT_EN adds a saturating taken-redirect counter.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic              clk_i,
   input logic              reset_i,
   pc_fetch_unit_if.master  bus
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      FETCH = 2'b01,
      EXEC  = 2'b10
   } state_e;

   state_e            state_q;
   logic [XLEN-1:0]   pc_q;
   logic [XLEN-1:0]   pc_d;
   logic [XLEN-1:0]   instr_q;
   logic              iread_q;
   logic              valid_q;
   logic              advance_c;

   // Advancing edge: instruction in EXEC retires and the next fetch begins.
   assign advance_c = (state_q == EXEC) && !bus.dbusywait;

   // Next fetch address: word-aligned redirect target or sequential (wraps naturally).
   always_comb begin
      pc_d = pc_q + XLEN'(4);
      if (bus.taken) begin
         pc_d = {bus.target[XLEN-1:2], 2'b00};
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         pc_q    <= {RESET_PC[XLEN-1:2], 2'b00};
         instr_q <= '0;
         iread_q <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               state_q <= FETCH;
               iread_q <= 1'b1;
               valid_q <= 1'b0;
            end
            FETCH: begin
               if (!bus.ibusywait) begin
                  instr_q <= bus.ireaddata;
                  valid_q <= 1'b1;
                  iread_q <= 1'b0;
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               if (advance_c) begin
                  pc_q    <= pc_d;
                  valid_q <= 1'b0;
                  iread_q <= 1'b1;
                  state_q <= FETCH;
               end
            end
            default: begin
               state_q <= IDLE;
               iread_q <= 1'b0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.pc          = pc_q;
   assign bus.iread       = iread_q;
   assign bus.instruction = instr_q;
   assign bus.instr_valid = valid_q;

`ifdef PC_REDIRECT_COUNT_EN
   logic [CNT_W-1:0] cnt_q;

   // Counts taken redirects on advancing edges, saturating at all-ones.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else if (advance_c && bus.taken && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign bus.redirect_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit; two instances (RESET_PC=0 and 0xFFFFFFFC) run in lockstep.
`timescale 1ns/1ps
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] target;
   logic        taken;
   logic        dbusywait;
   logic        ibusywait;
   logic [31:0] ireaddata;

   int n_chk = 0;
   int n_bad = 0;

   pc_fetch_unit_if b0 ();
   pc_fetch_unit_if b1 ();

   assign b0.target = target;    assign b1.target = target;
   assign b0.taken = taken;      assign b1.taken = taken;
   assign b0.dbusywait = dbusywait; assign b1.dbusywait = dbusywait;
   assign b0.ibusywait = ibusywait; assign b1.ibusywait = ibusywait;
   assign b0.ireaddata = ireaddata; assign b1.ireaddata = ireaddata;

   pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut0 (.clk_i(clk), .reset_i(rst), .bus(b0));
   pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut1 (.clk_i(clk), .reset_i(rst), .bus(b1));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return 32'h1300_0013 + a;
   endfunction

   initial begin
      rst = 1'b1; target = '0; taken = 1'b0; dbusywait = 1'b0; ibusywait = 1'b0; ireaddata = '0;
      tick(); tick();
      chk("rst_pc", b0.pc, 32'h0);
      chk("rst_iread", 32'(b0.iread), 32'h0);
      chk("rst_valid", 32'(b0.instr_valid), 32'h0);
      chk("rst_instr", b0.instruction, 32'h0);
      chk("rst_pc_hi", b1.pc, 32'hFFFF_FFFC);

      rst = 1'b0;
      tick();
      chk("idle2fetch_iread", 32'(b0.iread), 32'h1);
      chk("idle2fetch_valid", 32'(b0.instr_valid), 32'h0);

      // Four sequential instructions, zero wait.
      for (int k = 0; k < 4; k++) begin
         ireaddata = instr_of(32'(k * 4));
         if (k == 1) begin
            taken = 1'b1; target = 32'h200;   // must be ignored in FETCH
         end
         tick();
         chk("seq_valid", 32'(b0.instr_valid), 32'h1);
         chk("seq_iread", 32'(b0.iread), 32'h0);
         chk("seq_instr", b0.instruction, instr_of(32'(k * 4)));
         chk("seq_pc_exec", b0.pc, 32'(k * 4));
         taken = 1'b0; ireaddata = 32'hDEAD_BEEF;
         tick();
         chk("seq_valid_lo", 32'(b0.instr_valid), 32'h0);
         chk("seq_iread_hi", 32'(b0.iread), 32'h1);
         chk("seq_pc_next", b0.pc, 32'((k + 1) * 4));
         chk("seq_instr_hold", b0.instruction, instr_of(32'(k * 4)));
         if (k == 0) chk("wrap_pc", b1.pc, 32'h0);
      end
`ifdef PC_REDIRECT_COUNT_EN
      chk("cnt_no_redirect", 32'(b0.redirect_cnt), 32'h0);
`endif

      // Reset mid-FETCH with instruction memory busy.
      ibusywait = 1'b1;
      tick();
      chk("busy_pc", b0.pc, 32'h10);
      chk("busy_iread", 32'(b0.iread), 32'h1);
      rst = 1'b1; ireaddata = 32'hCAFE_F00D;
      tick();
      chk("midrst_iread", 32'(b0.iread), 32'h0);
      chk("midrst_pc", b0.pc, 32'h0);
      chk("midrst_valid", 32'(b0.instr_valid), 32'h0);
      chk("midrst_instr", b0.instruction, 32'h0);
      chk("midrst_pc_hi", b1.pc, 32'hFFFF_FFFC);
      rst = 1'b0;
      tick();
      chk("postrst_iread", 32'(b0.iread), 32'h1);

      // Get to FETCH at PC=4, then hold IBUSYWAIT for 3 cycles.
      ibusywait = 1'b0; ireaddata = instr_of(32'h0);
      tick(); tick();
      chk("pc4", b0.pc, 32'h4);
      ibusywait = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("istall_iread", 32'(b0.iread), 32'h1);
         chk("istall_pc", b0.pc, 32'h4);
         chk("istall_valid", 32'(b0.instr_valid), 32'h0);
      end
      ibusywait = 1'b0; ireaddata = instr_of(32'h4);
      tick();
      chk("istall_rise", 32'(b0.instr_valid), 32'h1);
      chk("istall_instr", b0.instruction, instr_of(32'h4));
      tick();
      ireaddata = instr_of(32'h8);
      tick();
      chk("exec_pc8", b0.pc, 32'h8);

      // Redirect from PC=8 to 0x40 (low target bits dropped).
      taken = 1'b1; target = 32'h0000_0043;
      tick();
      chk("redir_pc", b0.pc, 32'h40);
      chk("redir_iread", 32'(b0.iread), 32'h1);
`ifdef PC_REDIRECT_COUNT_EN
      chk("cnt_one", 32'(b0.redirect_cnt), 32'h1);
`endif
      taken = 1'b0; ireaddata = instr_of(32'h40);
      tick();

      // Data stall for 2 cycles with redirect pending; target sampled at release.
      dbusywait = 1'b1; taken = 1'b1; target = 32'h300;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("dstall_valid", 32'(b0.instr_valid), 32'h1);
         chk("dstall_pc", b0.pc, 32'h40);
         chk("dstall_iread", 32'(b0.iread), 32'h0);
      end
      dbusywait = 1'b0; target = 32'h100;
      tick();
      chk("dstall_redir_pc", b0.pc, 32'h100);
      chk("dstall_valid_lo", 32'(b0.instr_valid), 32'h0);
`ifdef PC_REDIRECT_COUNT_EN
      chk("cnt_two", 32'(b0.redirect_cnt), 32'h2);
`endif

      // Self-loop: target equals current PC.
      taken = 1'b0; ireaddata = instr_of(32'h100);
      tick();
      taken = 1'b1; target = 32'h100;
      tick();
      chk("selfloop_pc", b0.pc, 32'h100);
      chk("selfloop_iread", 32'(b0.iread), 32'h1);
`ifdef PC_REDIRECT_COUNT_EN
      chk("cnt_three", 32'(b0.redirect_cnt), 32'h3);
`endif

      // Reset wins over a ready fetch on the same edge.
      taken = 1'b0; rst = 1'b1;
      tick();
      chk("rst_prio_pc", b0.pc, 32'h0);
      chk("rst_prio_valid", 32'(b0.instr_valid), 32'h0);
      chk("rst_prio_instr", b0.instruction, 32'h0);
`ifdef PC_REDIRECT_COUNT_EN
      chk("cnt_rst", 32'(b0.redirect_cnt), 32'h0);
`endif

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, PC value loaded on reset (bits [1:0] SHALL be zero).
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset, sampled on rising CLK.
REQ-004 TARGET  input  32  jump/branch target from the target calculator; valid when TAKEN=1.
REQ-005 TAKEN  input  1  redirect request (JUMP | (BRANCH & ZERO)) for the instruction in EXEC.
REQ-006 DBUSYWAIT  input  1  data-memory stall; holds the current instruction in EXEC.
REQ-007 IBUSYWAIT  input  1  instruction-memory busy; read data valid on the edge where it is 0.
REQ-008 IREADDATA  input  32  instruction word returned by instruction memory.
REQ-009 PC  output  32  current fetch address, registered.
REQ-010 IREAD  output  1  instruction read request, registered.
REQ-011 INSTRUCTION  output  32  captured instruction, registered.
REQ-012 INSTR_VALID  output  1  INSTRUCTION is valid for decode/execute, registered.
REQ-013 REDIRECT_CNT  output  16  taken-redirect count; present only with PC_REDIRECT_COUNT_EN.

Function
REQ-014 States SHALL be IDLE, FETCH, EXEC, encoded in a 2-bit register; the fourth encoding SHALL return to IDLE on the next edge.
REQ-015 IDLE: IREAD=0, INSTR_VALID=0; next edge with RESET=0 -> FETCH, IREAD<=1.
REQ-016 FETCH: IREAD=1, PC stable; edge with IBUSYWAIT=1 -> remain in FETCH, no output change.
REQ-017 FETCH: edge with IBUSYWAIT=0 -> INSTRUCTION<=IREADDATA, INSTR_VALID<=1, IREAD<=0, state EXEC.
REQ-018 EXEC: edge with DBUSYWAIT=1 -> remain in EXEC; PC, INSTRUCTION and INSTR_VALID held.
REQ-019 EXEC: edge with DBUSYWAIT=0 -> PC<=TAKEN ? {TARGET[31:2],2'b00} : PC+4; INSTR_VALID<=0; IREAD<=1; state FETCH.
REQ-020 PC+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000) with no flag.
REQ-021 TAKEN, TARGET SHALL be ignored outside the advancing EXEC edge; IBUSYWAIT, IREADDATA ignored outside FETCH.
REQ-022 Zero-wait throughput SHALL be one instruction per 2 cycles; each IBUSYWAIT=1 cycle and each DBUSYWAIT=1 cycle adds exactly one cycle.
REQ-023 TAKEN and DBUSYWAIT both 1 in EXEC: stall wins; redirect applied on the first edge where DBUSYWAIT=0, using TAKEN/TARGET sampled then.
REQ-024 TARGET equal to current PC with TAKEN=1 SHALL refetch the same address (self-loop) without special handling.

Reset
REQ-025 RESET=1 at an edge SHALL, from any state: PC<=RESET_PC, state<=IDLE, IREAD<=0, INSTR_VALID<=0, INSTRUCTION<=32'h0, REDIRECT_CNT<=16'h0.
REQ-026 Reset during FETCH with IBUSYWAIT=1 SHALL abandon the read; IREAD low from the next cycle; late IREADDATA discarded.
REQ-027 Reset SHALL take priority over all other inputs on the same edge.

Configuration
REQ-028 Macro PC_REDIRECT_COUNT_EN defined: REDIRECT_CNT port exists; increments by 1 on each advancing EXEC edge with TAKEN=1; saturates at 16'hFFFF.
REQ-029 Macro PC_REDIRECT_COUNT_EN undefined: REDIRECT_CNT port and counter logic absent; all other behaviour identical.

Verification
REQ-030 RESET_PC=0, RESET 1 cycle, IBUSYWAIT=0, TAKEN=0, 4 instructions -> PC sequence 0,4,8,12; INSTR_VALID pulses every 2nd cycle; INSTRUCTION matches IREADDATA.
REQ-031 In EXEC at PC=8, TAKEN=1, TARGET=32'h00000040 -> next FETCH PC=32'h40; REDIRECT_CNT 0->1 (macro on).
REQ-032 IBUSYWAIT=1 for 3 cycles in FETCH at PC=4 -> IREAD held 4 cycles, PC=4 stable, INSTR_VALID rises on 4th edge.
REQ-033 DBUSYWAIT=1 for 2 cycles with TAKEN=1, TARGET=32'h100 -> INSTR_VALID held 3 cycles, then PC=32'h100.
REQ-034 RESET_PC=32'hFFFFFFFC, one sequential advance -> PC=32'h00000000; RESET asserted mid-FETCH with IBUSYWAIT=1 -> IDLE, PC=RESET_PC, IREAD=0 next cycle.
